// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUControl encodings and the sequencer state type.
package alu_pkg;

    localparam logic [5:0] ALU_ADD = 6'b100000;
    localparam logic [5:0] ALU_SUB = 6'b100010;
    localparam logic [5:0] ALU_MUL = 6'b011000;
    localparam logic [5:0] ALU_AND = 6'b100100;
    localparam logic [5:0] ALU_OR  = 6'b100101;
    localparam logic [5:0] ALU_NOR = 6'b100111;
    localparam logic [5:0] ALU_XOR = 6'b100110;
    localparam logic [5:0] ALU_SLL = 6'b000000;
    localparam logic [5:0] ALU_SRL = 6'b000010;
    localparam logic [5:0] ALU_SLT = 6'b101010;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a tie goes to the requester that did not win last.
module rr_arbiter2 (
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o,
    output logic       grant_idx_o
);

    always_comb begin
        grant_idx_o = 1'b0;
        if (valid_i == 2'b11) begin
            grant_idx_o = ~last_grant_i;
        end else if (valid_i[1]) begin
            grant_idx_o = 1'b1;
        end
        grant_o = {valid_i[1] & grant_idx_o, valid_i[0] & ~grant_idx_o};
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sequencer sharing one combinational ALU between two clients,
// with a multi-cycle hold for MUL and a per-client response handshake.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned MUL_LAT = 3
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Req0Valid,
    output logic        Req0Ready,
    input  logic [5:0]  Req0Ctl,
    input  logic [31:0] Req0A,
    input  logic [31:0] Req0B,
    input  logic        Req1Valid,
    output logic        Req1Ready,
    input  logic [5:0]  Req1Ctl,
    input  logic [31:0] Req1A,
    input  logic [31:0] Req1B,
    output logic        Rsp0Valid,
    input  logic        Rsp0Ready,
    output logic [31:0] Rsp0Result,
    output logic        Rsp0Zero,
    output logic        Rsp1Valid,
    input  logic        Rsp1Ready,
    output logic [31:0] Rsp1Result,
    output logic        Rsp1Zero,
    output logic [5:0]  AluControl,
    output logic [31:0] AluA,
    output logic [31:0] AluB,
    input  logic [31:0] AluResult
);

    localparam logic [3:0] MulCnt = 4'(MUL_LAT - 1);

    state_e      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        grant_id_q, grant_id_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] result_q, result_d;
    logic [5:0]  ctl_q, ctl_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;

    logic [1:0]  grant;
    logic        grant_idx;
    logic        rsp_fire;

    rr_arbiter2 u_arb (
        .valid_i      ({Req1Valid, Req0Valid}),
        .last_grant_i (last_grant_q),
        .grant_o      (grant),
        .grant_idx_o  (grant_idx)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        cnt_d        = cnt_q;
        result_d     = result_q;
        ctl_d        = ctl_q;
        a_d          = a_q;
        b_d          = b_q;
        rsp_fire     = grant_id_q ? Rsp1Ready : Rsp0Ready;

        unique case (state_q)
            StIdle: begin
                if (|grant) begin
                    ctl_d      = grant_idx ? Req1Ctl : Req0Ctl;
                    a_d        = grant_idx ? Req1A : Req0A;
                    b_d        = grant_idx ? Req1B : Req0B;
                    grant_id_d = grant_idx;
                    cnt_d      = (ctl_d == ALU_MUL) ? MulCnt : 4'd0;
                    state_d    = StExec;
                end
            end
            StExec: begin
                if (cnt_q == 4'd0) begin
                    result_d = AluResult;
                    state_d  = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (rsp_fire) begin
                    last_grant_d = grant_id_q;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Handshake outputs are forced low while reset is asserted.
    assign Req0Ready  = Reset_n & (state_q == StIdle) & grant[0];
    assign Req1Ready  = Reset_n & (state_q == StIdle) & grant[1];
    assign Rsp0Valid  = Reset_n & (state_q == StResp) & ~grant_id_q;
    assign Rsp1Valid  = Reset_n & (state_q == StResp) & grant_id_q;
    assign Rsp0Result = result_q;
    assign Rsp1Result = result_q;
    assign Rsp0Zero   = (result_q == 32'h0);
    assign Rsp1Zero   = (result_q == 32'h0);
    assign AluControl = ctl_q;
    assign AluA       = a_q;
    assign AluB       = b_q;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            grant_id_q   <= 1'b0;
            cnt_q        <= 4'd0;
            result_q     <= 32'h0;
            ctl_q        <= 6'h0;
            a_q          <= 32'h0;
            b_q          <= 32'h0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            cnt_q        <= cnt_d;
            result_q     <= result_d;
            ctl_q        <= ctl_d;
            a_q          <= a_d;
            b_q          <= b_d;
        end
    end

endmodule
